// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_LFSR   = 2'd3
    } mode_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/led_tick_gen.sv
// Pattern tick source: free-running prescaler while running, synchronised
// step-pin rising edges while stopped.
module led_tick_gen #(
    parameter int unsigned PRESC_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic step,
    output logic tick_i_c,
    output logic tick
);

    localparam int unsigned PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0] presc_cnt;
    logic               step_meta;
    logic               step_sync;
    logic               step_prev;
    logic               presc_wrap_c;
    logic               step_rise_c;

    assign presc_wrap_c = run && (presc_cnt == PRESC_LAST);
    assign step_rise_c  = step_sync && !step_prev;
    // Step edges only count while stopped; with run=1 the pin is ignored.
    assign tick_i_c     = presc_wrap_c || (!run && step_rise_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            if (run) begin
                presc_cnt <= (presc_cnt == PRESC_LAST) ? '0 : presc_cnt + PRESC_W'(1);
            end
            step_meta <= step;
            step_sync <= step_meta;
            step_prev <= step_sync;
            tick      <= tick_i_c;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern engine: COUNT / ROTATE / BOUNCE / LFSR patterns advanced by a
// prescaled tick or a step pin. Optional PWM brightness gate under LED_PWM_EN.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned       N_LEDS    = 8,
    parameter int unsigned       PRESC_DIV = 1000,
    parameter logic [N_LEDS-1:0] LFSR_TAPS = N_LEDS'(DEFAULT_LFSR_TAPS),
    parameter int unsigned       BR_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic [1:0]        mode,
    input  logic              load_en,
    input  logic [N_LEDS-1:0] load_data,
    input  logic [BR_W-1:0]   brightness,
    output logic [N_LEDS-1:0] leds,
    output logic              tick
);

    logic              tick_i_c;
    logic [N_LEDS-1:0] pattern;
    logic [N_LEDS-1:0] pattern_next_c;
    dir_t              dir;
    dir_t              dir_eff_c;
    dir_t              dir_next_c;
    mode_t             mode_c;
    mode_t             mode_q;
    logic              gate_c;

    led_tick_gen #(
        .PRESC_DIV (PRESC_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .step     (step),
        .tick_i_c (tick_i_c),
        .tick     (tick)
    );

    assign mode_c    = mode_t'(mode);
    // Any mode change restarts bounce travelling left.
    assign dir_eff_c = (mode_c != mode_q) ? LEFT : dir;

    always_comb begin
        pattern_next_c = pattern;
        dir_next_c     = dir_eff_c;
        if (load_en) begin
            pattern_next_c = load_data;
        end else if (tick_i_c) begin
            unique case (mode_c)
                MODE_COUNT: pattern_next_c = pattern + N_LEDS'(1);
                MODE_ROTATE: pattern_next_c = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
                MODE_BOUNCE: begin
                    if (dir_eff_c == LEFT) begin
                        if (pattern[N_LEDS-1]) begin
                            dir_next_c     = RIGHT;
                            pattern_next_c = pattern >> 1;
                        end else begin
                            pattern_next_c = pattern << 1;
                        end
                    end else begin
                        if (pattern[0]) begin
                            dir_next_c     = LEFT;
                            pattern_next_c = pattern << 1;
                        end else begin
                            pattern_next_c = pattern >> 1;
                        end
                    end
                end
                MODE_LFSR: begin
                    if (pattern == '0) begin
                        pattern_next_c = N_LEDS'(1);
                    end else begin
                        pattern_next_c = (pattern >> 1) ^ (pattern[0] ? LFSR_TAPS : '0);
                    end
                end
                default: pattern_next_c = pattern;
            endcase
        end
    end

`ifdef LED_PWM_EN
    logic [BR_W-1:0] pwm_cnt;

    assign gate_c = (pwm_cnt < brightness);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + BR_W'(1);
        end
    end
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign gate_c            = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= N_LEDS'(1);
            dir     <= LEFT;
            mode_q  <= MODE_COUNT;
            leds    <= '0;
        end else begin
            pattern <= pattern_next_c;
            dir     <= dir_next_c;
            mode_q  <= mode_c;
            leds    <= gate_c ? pattern : '0;
        end
    end

endmodule
